// File: rtl/i2c_slave_mem_pkg.sv
// ****************************************************************************
// * i2c_slave_pkg : shared state encoding and bus constants for i2c_slave_mem
// * Rev 1.0
// ****************************************************************************
`default_nettype none

package i2c_slave_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      ADDR_ACK  = 3'd2,
      WR_BYTE   = 3'd3,
      WR_ACK    = 3'd4,
      RD_BYTE   = 3'd5,
      RD_ACK    = 3'd6,
      WAIT_STOP = 3'd7
   } i2c_slv_state_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   // Address byte on the wire is {addr[6:0], rw}
   function automatic logic addr_hit(input logic [7:0] rx, input logic [6:0] addr);
      return (rx[7:1] == addr);
   endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_slave_mem_if.sv
// ****************************************************************************
// * i2c_slave_mem_if : I2C pad pins plus write-strobe sideband of i2c_slave_mem
// * Rev 1.0
// ****************************************************************************
`default_nettype none

interface i2c_slave_mem_if #(
   parameter int MEM_ADDR_WIDTH = 4,
   parameter int DATA_WIDTH     = 8
);
   logic                      scl_i;
   logic                      sda_i;
   logic                      scl_o;
   logic                      sda_o;
   logic                      busy_o;
   logic                      wr_stb_o;
   logic [MEM_ADDR_WIDTH-1:0] wr_addr_o;
   logic [DATA_WIDTH-1:0]     wr_data_o;

   modport slave (
      input  scl_i, sda_i,
      output scl_o, sda_o, busy_o, wr_stb_o, wr_addr_o, wr_data_o
   );

   modport master (
      output scl_i, sda_i,
      input  scl_o, sda_o, busy_o, wr_stb_o, wr_addr_o, wr_data_o
   );
endinterface

`default_nettype wire

// File: rtl/i2c_slave_mem_sync_edge.sv
// ****************************************************************************
// * i2c_sync_edge : 2-FF synchronizer with registered rise/fall pulses
// * Rev 1.0
// ****************************************************************************
`default_nettype none

module i2c_sync_edge #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);
   logic [2:0] sync_q, sync_d;
   logic       rise_q, rise_d;
   logic       fall_q, fall_d;

   // Pulses and level both appear three clocks after the pin edge
   always_comb begin
      sync_d = {sync_q[1:0], async_i};
      rise_d = sync_q[1] & ~sync_q[2];
      fall_d = ~sync_q[1] & sync_q[2];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {3{RESET_VAL}};
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign level_o = sync_q[2];
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

`default_nettype wire

// File: rtl/i2c_slave_mem.sv
// ****************************************************************************
// * i2c_slave_mem : I2C target with auto-incrementing byte register memory
// * Rev 1.0
// ****************************************************************************
`default_nettype none

module i2c_slave_mem
   import i2c_slave_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR     = 7'h22,
   parameter int         MEM_ADDR_WIDTH = 4,
   parameter int         DATA_WIDTH     = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   i2c_slave_mem_if.slave  bus
);
   localparam int                        c_mem_depth = 2**MEM_ADDR_WIDTH;
   localparam logic [MEM_ADDR_WIDTH-1:0] c_ptr_one   = 1;
   localparam logic [2:0]                c_cnt_one   = 3'd1;
   localparam logic [2:0]                c_last_bit  = 3'd7;

   logic scl_level, scl_rise, scl_fall;
   logic sda_level, sda_rise, sda_fall;

   i2c_sync_edge #(.RESET_VAL(1'b1)) u_scl_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (bus.scl_i),
      .level_o (scl_level),
      .rise_o  (scl_rise),
      .fall_o  (scl_fall)
   );

   i2c_sync_edge #(.RESET_VAL(1'b1)) u_sda_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (bus.sda_i),
      .level_o (sda_level),
      .rise_o  (sda_rise),
      .fall_o  (sda_fall)
   );

   i2c_slv_state_t            state_q, state_d;
   logic [2:0]                bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]     shift_q, shift_d;
   logic [MEM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic                      first_byte_q, first_byte_d;
   logic                      phase_q, phase_d;
   logic                      sda_out_q, sda_out_d;
   logic                      wr_stb_q, wr_stb_d;
   logic [MEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
   logic [DATA_WIDTH-1:0]     mem_q [c_mem_depth];
   logic [DATA_WIDTH-1:0]     mem_d [c_mem_depth];

   logic                      start_cond;
   logic                      stop_cond;
   logic [DATA_WIDTH-1:0]     rx_byte;

   assign start_cond = sda_fall & scl_level;
   assign stop_cond  = sda_rise & scl_level;
   assign rx_byte    = {shift_q[DATA_WIDTH-2:0], sda_level};

   // phase_q splits each ACK slot: 0 = before the 9th clock, 1 = during it
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      ptr_d        = ptr_q;
      first_byte_d = first_byte_q;
      phase_d      = phase_q;
      sda_out_d    = sda_out_q;
      wr_stb_d     = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      mem_d        = mem_q;

      if (start_cond) begin
         state_d   = ADDR;
         bit_cnt_d = '0;
         phase_d   = 1'b0;
         sda_out_d = 1'b1;
      end else if (stop_cond) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         phase_d   = 1'b0;
         sda_out_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
            end

            ADDR: begin
               if (scl_rise) begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + c_cnt_one;
                  phase_d   = 1'b0;
                  if (bit_cnt_q == c_last_bit) begin
                     state_d = addr_hit(rx_byte, SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
                  end
               end
            end

            ADDR_ACK: begin
               if (scl_fall) begin
                  if (!phase_q) begin
                     sda_out_d = I2C_ACK;
                     phase_d   = 1'b1;
                  end else begin
                     phase_d   = 1'b0;
                     bit_cnt_d = '0;
                     if (shift_q[0]) begin
                        state_d   = RD_BYTE;
                        shift_d   = mem_q[ptr_q];
                        sda_out_d = mem_q[ptr_q][DATA_WIDTH-1];
                     end else begin
                        state_d      = WR_BYTE;
                        first_byte_d = 1'b1;
                        sda_out_d    = 1'b1;
                     end
                  end
               end
            end

            WR_BYTE: begin
               if (scl_rise) begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + c_cnt_one;
                  if (bit_cnt_q == c_last_bit) begin
                     state_d = WR_ACK;
                     phase_d = 1'b0;
                     if (first_byte_q) begin
                        ptr_d        = rx_byte[MEM_ADDR_WIDTH-1:0];
                        first_byte_d = 1'b0;
                     end else begin
                        mem_d[ptr_q] = rx_byte;
                        wr_stb_d     = 1'b1;
                        wr_addr_d    = ptr_q;
                        wr_data_d    = rx_byte;
                        ptr_d        = ptr_q + c_ptr_one;
                     end
                  end
               end
            end

            WR_ACK: begin
               if (scl_fall) begin
                  if (!phase_q) begin
                     sda_out_d = I2C_ACK;
                     phase_d   = 1'b1;
                  end else begin
                     sda_out_d = 1'b1;
                     phase_d   = 1'b0;
                     bit_cnt_d = '0;
                     state_d   = WR_BYTE;
                  end
               end
            end

            RD_BYTE: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + c_cnt_one;
                  if (bit_cnt_q == c_last_bit) begin
                     state_d = RD_ACK;
                     phase_d = 1'b0;
                  end
               end else if (scl_fall) begin
                  shift_d   = {shift_q[DATA_WIDTH-2:0], shift_q[DATA_WIDTH-1]};
                  sda_out_d = shift_q[DATA_WIDTH-2];
               end
            end

            RD_ACK: begin
               if (scl_fall) begin
                  if (!phase_q) begin
                     sda_out_d = 1'b1;
                  end else begin
                     state_d   = RD_BYTE;
                     phase_d   = 1'b0;
                     bit_cnt_d = '0;
                     shift_d   = mem_q[ptr_q];
                     sda_out_d = mem_q[ptr_q][DATA_WIDTH-1];
                  end
               end else if (scl_rise && !phase_q) begin
                  ptr_d = ptr_q + c_ptr_one;
                  if (sda_level == I2C_NACK) begin
                     state_d = WAIT_STOP;
                  end else begin
                     phase_d = 1'b1;
                  end
               end
            end

            WAIT_STOP: begin
            end

            default: begin
               state_d   = IDLE;
               sda_out_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         ptr_q        <= '0;
         first_byte_q <= 1'b0;
         phase_q      <= 1'b0;
         sda_out_q    <= 1'b1;
         wr_stb_q     <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         for (int i = 0; i < c_mem_depth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         ptr_q        <= ptr_d;
         first_byte_q <= first_byte_d;
         phase_q      <= phase_d;
         sda_out_q    <= sda_out_d;
         wr_stb_q     <= wr_stb_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         mem_q        <= mem_d;
      end
   end

   assign bus.scl_o     = 1'b1;
   assign bus.sda_o     = sda_out_q;
   assign bus.busy_o    = (state_q != IDLE);
   assign bus.wr_stb_o  = wr_stb_q;
   assign bus.wr_addr_o = wr_addr_q;
   assign bus.wr_data_o = wr_data_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_mem.sv
// ****************************************************************************
// * tb_i2c_slave_mem : bit-banged I2C master against a byte-level memory model
// * Rev 1.0
// ****************************************************************************
`default_nettype none

module tb_i2c_slave_mem;
   localparam int Q = 6;  // quarter SCL period in clk cycles

   typedef struct packed {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;
   int   tests = 0;
   int   fails = 0;

   logic [7:0] m_mem [16];
   logic [3:0] m_ptr = '0;
   wr_t        exp_q [$];
   int         strobes = 0;
   logic [3:0] cap_addr = '0;
   logic [7:0] cap_data = '0;

   i2c_slave_mem_if #(.MEM_ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

   i2c_slave_mem #(.SLAVE_ADDR(7'h22), .MEM_ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   // Open-drain wired-AND of master and target
   assign bus.scl_i = scl_m & bus.scl_o;
   assign bus.sda_i = sda_m & bus.sda_o;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Per-cycle strobe checker against the model's expected write queue
   logic rst_seen = 1'b0;
   logic armed    = 1'b0;
   logic [3:0] last_a = '0;
   logic [7:0] last_d = '0;
   int   hold_bad = 0;
   wr_t  cmp_e;

   always @(posedge clk_i) rst_seen <= rst_i;

   always @(negedge clk_i) begin
      if (rst_seen) begin
         armed  = 1'b1;
         last_a = '0;
         last_d = '0;
      end
      if (armed) begin
         if (bus.wr_stb_o === 1'b1) begin
            strobes++;
            cap_addr = bus.wr_addr_o;
            cap_data = bus.wr_data_o;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL wr_stb: unexpected strobe addr %0d data 0x%0h, want no strobe",
                        bus.wr_addr_o, bus.wr_data_o);
            end else begin
               cmp_e = exp_q.pop_front();
               check("wr_addr", {28'd0, bus.wr_addr_o}, {28'd0, cmp_e.a});
               check("wr_data", {24'd0, bus.wr_data_o}, {24'd0, cmp_e.d});
            end
            last_a = bus.wr_addr_o;
            last_d = bus.wr_data_o;
         end else if (bus.wr_addr_o !== last_a || bus.wr_data_o !== last_d) begin
            hold_bad++;
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic i2c_start();
      if (!scl_m) begin
         sda_m = 1'b1;
         wait_clk(Q);
         scl_m = 1'b1;
         wait_clk(Q);
      end
      sda_m = 1'b0;
      wait_clk(Q);
      scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_clk(Q);
      sda_m = 1'b0;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(Q);
      sda_m = 1'b1;
      wait_clk(2*Q);
   endtask

   task automatic i2c_bit(input logic b, output logic r);
      wait_clk(Q);
      sda_m = b;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(Q);
      r = bus.sda_i;
      wait_clk(Q);
      scl_m = 1'b0;
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
      i2c_bit(1'b1, ack);
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] b);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         i2c_bit(1'b1, r);
         b[i] = r;
      end
      i2c_bit(nack, r);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_ptr = '0;
   endtask

   task automatic tx_write(input logic [6:0] a7, input logic [7:0] p, input int n,
                           input logic [7:0] d [4]);
      logic ack;
      logic match;
      match = (a7 == 7'h22);
      i2c_start();
      wr_byte({a7, 1'b0}, ack);
      check("addr ack", {31'd0, ack}, {31'd0, !match});
      wr_byte(p, ack);
      if (match) begin
         check("ptr ack", {31'd0, ack}, 32'd0);
         m_ptr = p[3:0];
         for (int i = 0; i < n; i++) begin
            exp_q.push_back({m_ptr, d[i]});
            m_mem[m_ptr] = d[i];
            m_ptr = m_ptr + 4'd1;
            wr_byte(d[i], ack);
            check("data ack", {31'd0, ack}, 32'd0);
         end
      end else begin
         check("nomatch ack", {31'd0, ack}, 32'd1);
         check("busy before stop", {31'd0, bus.busy_o}, 32'd1);
      end
      i2c_stop();
      check("busy after stop", {31'd0, bus.busy_o}, 32'd0);
   endtask

   task automatic tx_read(input logic set_ptr, input logic [7:0] p, input int n,
                          output logic [7:0] got [4]);
      logic       ack;
      logic [7:0] b;
      for (int i = 0; i < 4; i++) got[i] = 8'h00;
      i2c_start();
      if (set_ptr) begin
         wr_byte(8'h44, ack);
         check("rd ptr addr ack", {31'd0, ack}, 32'd0);
         wr_byte(p, ack);
         check("rd ptr ack", {31'd0, ack}, 32'd0);
         m_ptr = p[3:0];
         i2c_start();
      end
      wr_byte(8'h45, ack);
      check("rd addr ack", {31'd0, ack}, 32'd0);
      for (int i = 0; i < n; i++) begin
         rd_byte(i == n - 1, b);
         check("rd data", {24'd0, b}, {24'd0, m_mem[m_ptr]});
         got[i] = b;
         m_ptr  = m_ptr + 4'd1;
      end
      check("sda released after nack", {31'd0, bus.sda_o}, 32'd1);
      i2c_stop();
      check("busy after rd stop", {31'd0, bus.busy_o}, 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d [4];
      logic [7:0] got [4];
      logic       ack;
      logic       r;
      int         s0;
      model_reset();

      wait_clk(3);
      check("reset sda_o", {31'd0, bus.sda_o}, 32'd1);
      check("reset scl_o", {31'd0, bus.scl_o}, 32'd1);
      check("reset busy_o", {31'd0, bus.busy_o}, 32'd0);
      check("reset wr_stb_o", {31'd0, bus.wr_stb_o}, 32'd0);
      check("reset wr_addr_o", {28'd0, bus.wr_addr_o}, 32'd0);
      check("reset wr_data_o", {24'd0, bus.wr_data_o}, 32'd0);
      rst_i = 1'b0;
      wait_clk(4);

      d = '{8'h3C, 8'h00, 8'h00, 8'h00};
      tx_write(7'h22, 8'h05, 1, d);

      s0 = strobes;
      d = '{8'hA5, 8'h5A, 8'h00, 8'h00};
      tx_write(7'h22, 8'h03, 2, d);
      check("write strobe count", strobes - s0, 32'd2);
      check("write last addr", {28'd0, cap_addr}, 32'd4);
      check("write last data", {24'd0, cap_data}, 32'h5A);

      tx_read(1'b1, 8'h03, 2, got);
      check("read byte0", {24'd0, got[0]}, 32'hA5);
      check("read byte1", {24'd0, got[1]}, 32'h5A);
      tx_read(1'b0, 8'h00, 1, got);
      check("read ptr kept at 5", {24'd0, got[0]}, 32'h3C);

      s0 = strobes;
      tx_write(7'h23, 8'h11, 0, d);
      check("mismatch strobe count", strobes - s0, 32'd0);

      s0 = strobes;
      d = '{8'h11, 8'h22, 8'h00, 8'h00};
      tx_write(7'h22, 8'h0F, 2, d);
      check("wrap strobe count", strobes - s0, 32'd2);
      check("wrap last addr", {28'd0, cap_addr}, 32'd0);
      check("wrap last data", {24'd0, cap_data}, 32'h22);
      tx_read(1'b1, 8'h0F, 2, got);
      check("wrap read0", {24'd0, got[0]}, 32'h11);
      check("wrap read1", {24'd0, got[1]}, 32'h22);

      // Partial byte: pointer set, then STOP after four data bits
      s0 = strobes;
      i2c_start();
      wr_byte(8'h44, ack);
      check("partial addr ack", {31'd0, ack}, 32'd0);
      wr_byte(8'h04, ack);
      check("partial ptr ack", {31'd0, ack}, 32'd0);
      m_ptr = 4'd4;
      for (int i = 0; i < 4; i++) i2c_bit(1'b1, r);
      i2c_stop();
      check("partial strobe count", strobes - s0, 32'd0);
      tx_read(1'b1, 8'h04, 1, got);
      check("partial mem unchanged", {24'd0, got[0]}, 32'h5A);

      for (int t = 0; t < 24; t++) begin
         int kind;
         int n;
         kind = $urandom_range(0, 3);
         n    = $urandom_range(0, 3);
         for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
         case (kind)
            0, 1: tx_write(7'h22, 8'($urandom), n, d);
            2:    tx_read(1'b1, 8'($urandom), n + 1, got);
            default: begin
               if ($urandom_range(0, 1) == 0) tx_read(1'b0, 8'h00, n + 1, got);
               else tx_write(7'($urandom_range(0, 127)), 8'($urandom), n, d);
            end
         endcase
      end

      // Reset while the target is pulling SDA low on a data bit (0xA5 bit 6)
      d = '{8'hA5, 8'h00, 8'h00, 8'h00};
      tx_write(7'h22, 8'h03, 1, d);
      i2c_start();
      wr_byte(8'h44, ack);
      wr_byte(8'h03, ack);
      i2c_start();
      wr_byte(8'h45, ack);
      check("rst-rd addr ack", {31'd0, ack}, 32'd0);
      i2c_bit(1'b1, r);
      check("rst-rd bit7", {31'd0, r}, 32'd1);
      wait_clk(Q);
      sda_m = 1'b1;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(Q);
      check("rst-rd sda low", {31'd0, bus.sda_o}, 32'd0);
      rst_i = 1'b1;
      wait_clk(1);
      check("rst-rd sda released", {31'd0, bus.sda_o}, 32'd1);
      check("rst-rd busy low", {31'd0, bus.busy_o}, 32'd0);
      rst_i = 1'b0;
      model_reset();
      wait_clk(Q);
      scl_m = 1'b0;
      i2c_stop();
      tx_read(1'b0, 8'h00, 1, got);
      check("post-reset read", {24'd0, got[0]}, 32'h00);

      wait_clk(4);
      check("wr outputs held between strobes", hold_bad, 32'd0);
      check("expected writes drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/i2c_slave_mem.md
# i2c_slave_mem

Synthesizable I2C responder (target) with a small byte-addressable register memory. It sits on the far end of an iicmb_m_wb I2C bus and answers one 7-bit address. Supported transfers: a pointer write, data writes with pointer auto-increment, and sequential reads with repeated START. It replaces the behavioural slave model in benches that need a real RTL counterpart, and ships as a reusable peripheral.

## Interface
Parameters:
- SLAVE_ADDR, 7'h22: 7-bit I2C address this block answers.
- MEM_ADDR_WIDTH, 4: memory depth is 2**MEM_ADDR_WIDTH bytes.
- DATA_WIDTH, 8: byte width. Fixed at 8.

Ports:
- clk_i, in, 1: system clock. Must run at 20× SCL or faster.
- rst_i, in, 1: reset. Synchronous, active-high, sampled on the rising edge of clk_i.
- scl_i, in, 1: I2C clock from the pad. Asynchronous.
- sda_i, in, 1: I2C data from the pad. Asynchronous.
- scl_o, out, 1: open-drain clock output; 1 releases the line. Tied to 1 (no clock stretching).
- sda_o, out, 1: open-drain data output; 0 pulls the line low, 1 releases it.
- busy_o, out, 1: high while the state is not IDLE.
- wr_stb_o, out, 1: one-cycle pulse when a data byte is stored.
- wr_addr_o, out, MEM_ADDR_WIDTH: memory address of the stored byte.
- wr_data_o, out, 8: value of the stored byte.

## Operation
- Input conditioning: scl_i and sda_i each pass through a 2-FF synchronizer, then an edge detector. This yields scl_rise, scl_fall and sda_rise/sda_fall.
- START: sda_fall while synchronized scl = 1. Legal in any state, including a repeated START. Effects: go to ADDR, clear the bit counter, release sda_o.
- STOP: sda_rise while synchronized scl = 1. Legal in any state. Effects: go to IDLE, release sda_o, discard any partial byte.
- Data sampling: data bits are sampled MSB first on scl_rise. A 3-bit counter counts bits 0..7.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits. Match on {addr,rw} with addr == SLAVE_ADDR → ADDR_ACK. Mismatch → WAIT_STOP, sda stays released.
  - ADDR_ACK: drive sda_o = 0 for the 9th clock. Next state: RD_BYTE if rw = 1, else WR_BYTE with first_byte set.
  - WR_BYTE: shift in 8 bits, then → WR_ACK.
    - If first_byte: ptr ← byte[MEM_ADDR_WIDTH-1:0]; clear first_byte.
    - Otherwise: mem[ptr] ← byte; pulse wr_stb_o; ptr ← ptr+1.
  - WR_ACK: drive ACK (0), then → WR_BYTE.
  - RD_BYTE: shift_reg loads mem[ptr] on entry. Drive the bits MSB first. After 8 bits → RD_ACK.
  - RD_ACK: release sda_o and sample the master's bit on scl_rise. ptr ← ptr+1 either way. ACK (0) → RD_BYTE. NACK (1) → WAIT_STOP.
  - WAIT_STOP: sda released; leave only on START or STOP.
- Pointer rules:
  - Width MEM_ADDR_WIDTH; wraps from max to 0.
  - Kept across transactions; only rst_i clears it.
  - A read immediately after a pointer-write plus repeated START starts at that pointer.
- Memory rules: every write byte is ACKed. No read-only locations.

## Timing
- Synchronizer plus edge detect: an edge is flagged 3 clk_i cycles after the pin edge.
- sda_o changes only in the cycle after scl_fall is flagged, i.e. 4 cycles after the pin falls. It never changes while synchronized scl = 1, except:
  - release forced by START or STOP;
  - release forced by rst_i.
- ACK is asserted on the scl_fall that ends bit 8, and held until the scl_fall that ends bit 9.
- wr_stb_o, wr_addr_o and wr_data_o update in the cycle after the scl_rise of bit 8. wr_addr_o and wr_data_o hold until the next strobe.
- Reset: applies on the first clk_i edge with rst_i = 1. Values after reset:
  - sda_o = 1, scl_o = 1, busy_o = 0, wr_stb_o = 0;
  - wr_addr_o = 0, wr_data_o = 0, ptr = 0;
  - all memory bytes = 0, state = IDLE.
- Reset mid-transfer: the line is released on the next edge. The block then ignores the bus until the next START.
- START and STOP cannot occur in the same cycle. A START in the same cycle as an scl_rise data sample is impossible, because START requires a steady high scl.

## Structure
- Package i2c_slave_pkg holds:
  - state enum i2c_slv_state_t {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP};
  - constants I2C_ACK = 1'b0 and I2C_NACK = 1'b1.
- Sub-module i2c_sync_edge: 2-FF synchronizer plus rise/fall pulse outputs. Instantiated once for scl and once for sda.
- Memory: a register array inside i2c_slave_mem, reset synchronously.

## Test plan
- Write: START, 0x44, 0x03, 0xA5, 0x5A, STOP.
  - Required: four ACKs; wr_stb_o pulses with (3, 0xA5) then (4, 0x5A); busy_o = 0 after STOP.
- Read: START, 0x44, 0x03, Sr, 0x45, read with ACK, read with NACK, STOP.
  - Required: bytes read are 0xA5 then 0x5A; ptr ends at 5; sda released after the NACK.
- Address mismatch: START, 0x46, 0x11, STOP.
  - Required: sda_o = 1 through the 9th clock; no wr_stb_o; busy_o = 1 until STOP.
- Wrap: write pointer 0x0F, then data 0x11, 0x22; then read 2 bytes from pointer 0x0F.
  - Required: strobes at (15, 0x11) and (0, 0x22); the read returns 0x11, 0x22.
- Partial byte: STOP after 4 data bits of a write byte.
  - Required: no wr_stb_o; a later read shows the memory unchanged.
- Reset mid-read: assert rst_i while sda_o = 0 on a data bit.
  - Required: next cycle sda_o = 1 and busy_o = 0; a subsequent read at pointer 0 returns 0x00.
